// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage data-memory access sequencer. Drives one load/store
//            at a time onto the data-bus request/response handshake, holds
//            the pipeline while the access is in flight, and aligns and
//            extends load data for writeback. Non-memory instructions pass
//            straight through with no stall.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,

    // Operation carried from EX/MEM
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  reg_write_addr_i,
    input  logic        reg_write_en_i,
    input  logic [31:0] reg_write_data_i,
    input  logic        flush_i,

    // Data-bus request channel
    output logic        dreq_o,
    output logic        dwe_o,
    output logic [31:0] daddr_o,
    output logic [3:0]  dbe_o,
    output logic [31:0] dwdata_o,
    input  logic        dready_i,

    // Data-bus response channel
    input  logic        drvalid_i,
    input  logic [31:0] drdata_i,

    // Pipeline control and writeback
    output logic        stall_req_o,
    output logic [4:0]  reg_write_addr_o,
    output logic        reg_write_en_o,
    output logic [31:0] reg_write_data_o,

    // Address exceptions
    output logic        addr_err_load_o,
    output logic        addr_err_store_o,
    output logic [31:0] bad_vaddr_o
);

    // ------------------------------------------------------------------------
    // Operation encodings (9..15 decode as no memory access)
    // ------------------------------------------------------------------------
    localparam logic [3:0] C_OP_NONE = 4'd0;
    localparam logic [3:0] C_OP_LB   = 4'd1;
    localparam logic [3:0] C_OP_LBU  = 4'd2;
    localparam logic [3:0] C_OP_LH   = 4'd3;
    localparam logic [3:0] C_OP_LHU  = 4'd4;
    localparam logic [3:0] C_OP_LW   = 4'd5;
    localparam logic [3:0] C_OP_SB   = 4'd6;
    localparam logic [3:0] C_OP_SH   = 4'd7;
    localparam logic [3:0] C_OP_SW   = 4'd8;

    // ------------------------------------------------------------------------
    // Access sequencer states
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_REQ  = 2'd1;
    localparam logic [1:0] C_WAIT = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic        killed_q, killed_d;
    logic [31:0] rdata_q,  rdata_d;

    // Operation decode
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_is_signed;
    logic        w_mem_op;
    logic        w_misaligned;

    // Store lane steering
    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;

    // Load alignment
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;
    logic [31:0] w_load_data;

    // Classify the incoming operation by direction, size and signedness
    always_comb begin
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_byte   = 1'b0;
        w_is_half   = 1'b0;
        w_is_word   = 1'b0;
        w_is_signed = 1'b0;
        case (mem_op_i)
            C_OP_LB:  begin w_is_load  = 1'b1; w_is_byte = 1'b1; w_is_signed = 1'b1; end
            C_OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            C_OP_LH:  begin w_is_load  = 1'b1; w_is_half = 1'b1; w_is_signed = 1'b1; end
            C_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            C_OP_LW:  begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            C_OP_SB:  begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            C_OP_SH:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
            C_OP_SW:  begin w_is_store = 1'b1; w_is_word = 1'b1; end
            C_OP_NONE: ;
            default: ;
        endcase
    end

    assign w_mem_op     = w_is_load | w_is_store;
    assign w_misaligned = (w_is_half & mem_addr_i[0]) |
                          (w_is_word & (mem_addr_i[1:0] != 2'b00));

    // Little-endian store lanes: byte/half data is replicated across the word
    // so the bus only needs the byte enables to pick the right lanes
    always_comb begin
        w_store_be   = 4'b1111;
        w_store_data = mem_wdata_i;
        if (w_is_byte) begin
            w_store_be   = 4'b0001 << mem_addr_i[1:0];
            w_store_data = {4{mem_wdata_i[7:0]}};
        end else if (w_is_half) begin
            w_store_be   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            w_store_data = {2{mem_wdata_i[15:0]}};
        end
    end

    // Pick the addressed byte/half out of the captured read word and extend it
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    w_load_byte = rdata_q[7:0];
            2'd1:    w_load_byte = rdata_q[15:8];
            2'd2:    w_load_byte = rdata_q[23:16];
            default: w_load_byte = rdata_q[31:24];
        endcase
        w_load_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];

        w_load_data = rdata_q;
        if (w_is_byte) begin
            w_load_data = {{24{w_is_signed & w_load_byte[7]}}, w_load_byte};
        end else if (w_is_half) begin
            w_load_data = {{16{w_is_signed & w_load_half[15]}}, w_load_half};
        end
    end

    // Next-state logic: sequence the access and track a flush that lands
    // while a response is still owed by the bus
    always_comb begin
        state_d  = state_q;
        killed_d = killed_q;
        rdata_d  = rdata_q;
        case (state_q)
            C_IDLE: begin
                killed_d = 1'b0;
                if (!flush_i && w_mem_op && !w_misaligned) begin
                    state_d = C_REQ;
                end
            end
            C_REQ: begin
                // A request not yet accepted can simply be withdrawn
                if (flush_i) begin
                    state_d = C_IDLE;
                end else if (dready_i) begin
                    state_d = C_WAIT;
                end
            end
            C_WAIT: begin
                // Once accepted, the response must still be absorbed
                if (flush_i) begin
                    killed_d = 1'b1;
                end
                if (drvalid_i) begin
                    rdata_d = drdata_i;
                    if (killed_q || flush_i) begin
                        state_d  = C_IDLE;
                        killed_d = 1'b0;
                    end else begin
                        state_d = C_DONE;
                    end
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d  = C_IDLE;
                killed_d = 1'b0;
            end
        endcase
    end

    // State, kill flag and captured read data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= C_IDLE;
            killed_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            rdata_q  <= rdata_d;
        end
    end

    // Output decode: bus request, stall, writeback and exception fields
    always_comb begin
        dreq_o           = 1'b0;
        dwe_o            = 1'b0;
        daddr_o          = 32'd0;
        dbe_o            = 4'd0;
        dwdata_o         = 32'd0;
        stall_req_o      = 1'b0;
        reg_write_addr_o = 5'd0;
        reg_write_en_o   = 1'b0;
        reg_write_data_o = 32'd0;
        addr_err_load_o  = 1'b0;
        addr_err_store_o = 1'b0;
        bad_vaddr_o      = 32'd0;
        if (!rst) begin
            case (state_q)
                C_IDLE: begin
                    if (flush_i) begin
                        // Killed instruction: nothing leaves this stage
                    end else if (!w_mem_op) begin
                        reg_write_addr_o = reg_write_addr_i;
                        reg_write_en_o   = reg_write_en_i;
                        reg_write_data_o = reg_write_data_i;
                    end else if (w_misaligned) begin
                        addr_err_load_o  = w_is_load;
                        addr_err_store_o = w_is_store;
                        bad_vaddr_o      = mem_addr_i;
                        reg_write_addr_o = reg_write_addr_i;
                    end else begin
                        stall_req_o = 1'b1;
                    end
                end
                C_REQ: begin
                    if (!flush_i) begin
                        dreq_o      = 1'b1;
                        dwe_o       = w_is_store;
                        daddr_o     = {mem_addr_i[31:2], 2'b00};
                        dbe_o       = w_is_store ? w_store_be : 4'b1111;
                        dwdata_o    = w_is_store ? w_store_data : 32'd0;
                        stall_req_o = 1'b1;
                    end
                end
                C_WAIT: begin
                    stall_req_o = !flush_i;
                end
                C_DONE: begin
                    reg_write_addr_o = reg_write_addr_i;
                    if (w_is_load) begin
                        reg_write_en_o   = reg_write_en_i & !flush_i;
                        reg_write_data_o = w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  reg_write_addr_i;
    logic        reg_write_en_i;
    logic [31:0] reg_write_data_i;
    logic        flush_i;
    logic        dreq_o;
    logic        dwe_o;
    logic [31:0] daddr_o;
    logic [3:0]  dbe_o;
    logic [31:0] dwdata_o;
    logic        dready_i;
    logic        drvalid_i;
    logic [31:0] drdata_i;
    logic        stall_req_o;
    logic [4:0]  reg_write_addr_o;
    logic        reg_write_en_o;
    logic [31:0] reg_write_data_o;
    logic        addr_err_load_o;
    logic        addr_err_store_o;
    logic [31:0] bad_vaddr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .mem_op_i         (mem_op_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_en_i   (reg_write_en_i),
        .reg_write_data_i (reg_write_data_i),
        .flush_i          (flush_i),
        .dreq_o           (dreq_o),
        .dwe_o            (dwe_o),
        .daddr_o          (daddr_o),
        .dbe_o            (dbe_o),
        .dwdata_o         (dwdata_o),
        .dready_i         (dready_i),
        .drvalid_i        (drvalid_i),
        .drdata_i         (drdata_i),
        .stall_req_o      (stall_req_o),
        .reg_write_addr_o (reg_write_addr_o),
        .reg_write_en_o   (reg_write_en_o),
        .reg_write_data_o (reg_write_data_o),
        .addr_err_load_o  (addr_err_load_o),
        .addr_err_store_o (addr_err_store_o),
        .bad_vaddr_o      (bad_vaddr_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] ra, input logic re, input logic [31:0] rd);
        mem_op_i         = op;
        mem_addr_i       = addr;
        mem_wdata_i      = wdata;
        reg_write_addr_i = ra;
        reg_write_en_i   = re;
        reg_write_data_i = rd;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush_i = 1'b0; dready_i = 1'b0; drvalid_i = 1'b0; drdata_i = 32'h0;
        set_op(4'd5, 32'h100, 32'h0, 5'd5, 1'b1, 32'h1234);
        tick; tick;
        @(negedge clk);
        checks++;
        if ({dreq_o, stall_req_o, reg_write_en_o, reg_write_addr_o, reg_write_data_o,
             addr_err_load_o, addr_err_store_o, bad_vaddr_o, daddr_o, dbe_o} !== 83'd0) begin
            errors++;
            $display("FAIL reset_outputs: dreq=%b stall=%b en=%b waddr=%h wdata=%h bad=%h, required all zero",
                     dreq_o, stall_req_o, reg_write_en_o, reg_write_addr_o, reg_write_data_o, bad_vaddr_o);
        end
        tick;
        rst = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || dreq_o !== 1'b0 || reg_write_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: stall=%b dreq=%b en=%b, required 0/0/0", stall_req_o, dreq_o, reg_write_en_o);
        end
        tick;
    endtask

    task automatic test_passthrough;
        set_op(4'd0, 32'h104, 32'h0, 5'd7, 1'b1, 32'hCAFEBABE);
        @(negedge clk);
        checks++;
        if (reg_write_addr_o !== 5'd7 || reg_write_en_o !== 1'b1 || reg_write_data_o !== 32'hCAFEBABE ||
            stall_req_o !== 1'b0 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_none: addr=%0d en=%b data=%h stall=%b dreq=%b, required 7/1/cafebabe/0/0",
                     reg_write_addr_o, reg_write_en_o, reg_write_data_o, stall_req_o, dreq_o);
        end
        tick;
        set_op(4'd12, 32'h108, 32'h0, 5'd31, 1'b1, 32'h0F0F0F0F);
        @(negedge clk);
        checks++;
        if (reg_write_addr_o !== 5'd31 || reg_write_en_o !== 1'b1 || reg_write_data_o !== 32'h0F0F0F0F ||
            stall_req_o !== 1'b0 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_op12: addr=%0d en=%b data=%h stall=%b dreq=%b, required 31/1/0f0f0f0f/0/0",
                     reg_write_addr_o, reg_write_en_o, reg_write_data_o, stall_req_o, dreq_o);
        end
        tick;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    // One zero-wait-state access: IDLE, REQ, WAIT (response same cycle), DONE
    task automatic test_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic exp_dwe, input logic [31:0] exp_daddr, input logic [3:0] exp_be,
                               input logic [31:0] exp_dw, input logic exp_en, input logic [31:0] exp_data);
        set_op(op, addr, wdata, 5'd3, 1'b1, 32'h55);
        dready_i = 1'b0; drvalid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b1 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle0: stall=%b dreq=%b, required 1/0", name, stall_req_o, dreq_o);
        end
        tick;
        dready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (dreq_o !== 1'b1 || dwe_o !== exp_dwe || daddr_o !== exp_daddr || dbe_o !== exp_be ||
            stall_req_o !== 1'b1 || (exp_dwe && dwdata_o !== exp_dw)) begin
            errors++;
            $display("FAIL %s request: dreq=%b dwe=%b daddr=%h dbe=%b dwdata=%h stall=%b, required 1/%b/%h/%b/%h/1",
                     name, dreq_o, dwe_o, daddr_o, dbe_o, dwdata_o, stall_req_o, exp_dwe, exp_daddr, exp_be, exp_dw);
        end
        tick;
        dready_i = 1'b0; drvalid_i = 1'b1; drdata_i = rdata;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b1 || dreq_o !== 1'b0 || reg_write_en_o !== 1'b0) begin
            errors++;
            $display("FAIL %s wait: stall=%b dreq=%b en=%b, required 1/0/0", name, stall_req_o, dreq_o, reg_write_en_o);
        end
        tick;
        drvalid_i = 1'b0; drdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || reg_write_en_o !== exp_en || reg_write_addr_o !== 5'd3 ||
            (exp_en && reg_write_data_o !== exp_data)) begin
            errors++;
            $display("FAIL %s writeback: stall=%b en=%b addr=%0d data=%h, required 0/%b/3/%h",
                     name, stall_req_o, reg_write_en_o, reg_write_addr_o, reg_write_data_o, exp_en, exp_data);
        end
        tick;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_misaligned;
        set_op(4'd5, 32'h101, 32'h0, 5'd4, 1'b1, 32'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (addr_err_load_o !== 1'b1 || addr_err_store_o !== 1'b0 || bad_vaddr_o !== 32'h101 ||
                stall_req_o !== 1'b0 || dreq_o !== 1'b0 || reg_write_en_o !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_lw cyc%0d: errL=%b errS=%b bad=%h stall=%b dreq=%b en=%b, required 1/0/101/0/0/0",
                         i, addr_err_load_o, addr_err_store_o, bad_vaddr_o, stall_req_o, dreq_o, reg_write_en_o);
            end
            tick;
        end
        set_op(4'd8, 32'h102, 32'h12345678, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (addr_err_store_o !== 1'b1 || addr_err_load_o !== 1'b0 || bad_vaddr_o !== 32'h102 ||
            stall_req_o !== 1'b0 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_sw: errS=%b errL=%b bad=%h stall=%b dreq=%b, required 1/0/102/0/0",
                     addr_err_store_o, addr_err_load_o, bad_vaddr_o, stall_req_o, dreq_o);
        end
        tick;
        set_op(4'd3, 32'h203, 32'h0, 5'd2, 1'b1, 32'h0);
        @(negedge clk);
        checks++;
        if (addr_err_load_o !== 1'b1 || bad_vaddr_o !== 32'h203 || stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_lh: errL=%b bad=%h stall=%b, required 1/203/0", addr_err_load_o, bad_vaddr_o, stall_req_o);
        end
        tick;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_states;
        int   stalls = 0;
        int   dreqs  = 0;
        logic done   = 1'b0;
        logic [31:0] got = 32'h0;
        set_op(4'd5, 32'h400, 32'h0, 5'd6, 1'b1, 32'h0);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            dready_i  = (cyc == 4);
            drvalid_i = (cyc == 6);
            drdata_i  = (cyc == 6) ? 32'h0BADF00D : 32'h0;
            @(negedge clk);
            if (stall_req_o) stalls++;
            if (dreq_o) begin
                dreqs++;
                checks++;
                if (daddr_o !== 32'h400 || dbe_o !== 4'b1111 || dwe_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_states_stable cyc%0d: daddr=%h dbe=%b dwe=%b, required 400/1111/0",
                             cyc, daddr_o, dbe_o, dwe_o);
                end
            end
            if (!stall_req_o && reg_write_en_o) begin
                done = 1'b1;
                got  = reg_write_data_o;
            end
            tick;
        end
        dready_i = 1'b0; drvalid_i = 1'b0; drdata_i = 32'h0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        checks++;
        if (!done || got !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL wait_states_result: done=%b data=%h, required 1/0badf00d", done, got);
        end
        checks++;
        if (stalls != 7 || dreqs != 4) begin
            errors++;
            $display("FAIL wait_states_count: stalls=%0d dreq_cycles=%0d, required 7/4", stalls, dreqs);
        end
    endtask

    task automatic test_flush_idle;
        set_op(4'd5, 32'h800, 32'h0, 5'd4, 1'b1, 32'h0);
        flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || dreq_o !== 1'b0 || reg_write_en_o !== 1'b0 || addr_err_load_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: stall=%b dreq=%b en=%b errL=%b, required 0/0/0/0",
                     stall_req_o, dreq_o, reg_write_en_o, addr_err_load_o);
        end
        tick;
        flush_i = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd4, 1'b1, 32'h77);
        @(negedge clk);
        checks++;
        if (dreq_o !== 1'b0 || reg_write_en_o !== 1'b1 || reg_write_data_o !== 32'h77) begin
            errors++;
            $display("FAIL flush_idle_after: dreq=%b en=%b data=%h, required 0/1/77", dreq_o, reg_write_en_o, reg_write_data_o);
        end
        tick;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_flush_wait;
        set_op(4'd5, 32'h500, 32'h0, 5'd8, 1'b1, 32'h0);
        tick;                                   // IDLE -> REQ
        dready_i = 1'b1;
        tick;                                   // REQ -> WAIT
        dready_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || reg_write_en_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_cycle: stall=%b en=%b, required 0/0", stall_req_o, reg_write_en_o);
        end
        tick;
        flush_i = 1'b0;
        set_op(4'd5, 32'h600, 32'h0, 5'd9, 1'b1, 32'h0);
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b1 || reg_write_en_o !== 1'b0 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_hold: stall=%b en=%b dreq=%b, required 1/0/0", stall_req_o, reg_write_en_o, dreq_o);
        end
        tick;
        drvalid_i = 1'b1; drdata_i = 32'h11111111;
        tick;
        drvalid_i = 1'b0; drdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (reg_write_en_o !== 1'b0 || stall_req_o !== 1'b1 || dreq_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_absorb: en=%b stall=%b dreq=%b, required 0/1/0", reg_write_en_o, stall_req_o, dreq_o);
        end
        tick;
        dready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (dreq_o !== 1'b1 || daddr_o !== 32'h600) begin
            errors++;
            $display("FAIL flush_wait_next_req: dreq=%b daddr=%h, required 1/600", dreq_o, daddr_o);
        end
        tick;
        dready_i = 1'b0; drvalid_i = 1'b1; drdata_i = 32'h22222222;
        tick;
        drvalid_i = 1'b0; drdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (reg_write_en_o !== 1'b1 || reg_write_data_o !== 32'h22222222 || reg_write_addr_o !== 5'd9) begin
            errors++;
            $display("FAIL flush_wait_next_wb: en=%b data=%h addr=%0d, required 1/22222222/9",
                     reg_write_en_o, reg_write_data_o, reg_write_addr_o);
        end
        tick;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        set_op(4'd5, 32'h700, 32'h0, 5'd10, 1'b1, 32'h0);
        tick;                                   // IDLE -> REQ
        @(negedge clk);
        checks++;
        if (dreq_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req: dreq=%b, required 1", dreq_o);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        drvalid_i = 1'b1; drdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if ({dreq_o, dwe_o, stall_req_o, reg_write_en_o, reg_write_addr_o, reg_write_data_o,
             addr_err_load_o, addr_err_store_o, bad_vaddr_o, daddr_o, dbe_o} !== 84'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: dreq=%b stall=%b en=%b daddr=%h dbe=%b, required all zero",
                     dreq_o, stall_req_o, reg_write_en_o, daddr_o, dbe_o);
        end
        tick;
        drvalid_i = 1'b0; drdata_i = 32'h0;
        @(negedge clk);
        checks++;
        if (stall_req_o !== 1'b0 || reg_write_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stray_rvalid: stall=%b en=%b, required 0/0", stall_req_o, reg_write_en_o);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_access("lw",  4'd5, 32'h100, 32'h0,      32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF);
        test_access("lb",  4'd1, 32'h103, 32'h0,      32'h80123456, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFFFF80);
        test_access("lbu", 4'd2, 32'h103, 32'h0,      32'h80123456, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00000080);
        test_access("lh",  4'd3, 32'h102, 32'h0,      32'h80123456, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFF8012);
        test_access("lhu", 4'd4, 32'h102, 32'h0,      32'h80123456, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00008012);
        test_access("lb1", 4'd1, 32'h101, 32'h0,      32'h80123456, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00000034);
        test_access("sh",  4'd7, 32'h202, 32'h1234,   32'h0,        1'b1, 32'h200, 4'b1100, 32'h12341234, 1'b0, 32'h0);
        test_access("sb",  4'd6, 32'h201, 32'hFFAB,   32'h0,        1'b1, 32'h200, 4'b0010, 32'hABABABAB, 1'b0, 32'h0);
        test_access("sw",  4'd8, 32'h300, 32'h11223344, 32'h0,      1'b1, 32'h300, 4'b1111, 32'h11223344, 1'b0, 32'h0);
        test_misaligned;
        test_wait_states;
        test_flush_idle;
        test_flush_wait;
        test_reset_mid;
        test_access("lw_after_rst", 4'd5, 32'h104, 32'h0, 32'h13579BDF, 1'b0, 32'h104, 4'b1111, 32'h0, 1'b1, 32'h13579BDF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
